// File: rtl/serpent_de_iter.sv
`default_nettype none
// ============================================================================
//  Module   : serpent_de_iter
//  Purpose  : Iterative Serpent block decryptor for the XTS decrypt datapath.
//             Accepts one 128-bit ciphertext block and runs the 32 inverse
//             rounds at one round per clock. It then returns the plaintext
//             block. Each round undoes one encryption round in this order:
//             inverse LT, inverse S-box, then subkey mix. Bitslice words are
//             word0 = bits[31:0] .. word3 = bits[127:96].
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk      in   1    clock, rising edge
//    i_rst_n    in   1    asynchronous active-low reset
//    i_valid    in   1    ciphertext block valid (sampled in IDLE only)
//    o_ready    out  1    high only in IDLE
//    i_data     in   128  ciphertext block
//    o_key_idx  out  6    subkey index requested this cycle (0..32)
//    i_subkey   in   128  K[o_key_idx], combinational same-cycle return
//    o_valid    out  1    plaintext valid (DONE)
//    i_ready    in   1    downstream accepts plaintext (sampled in DONE only)
//    o_data     out  128  plaintext block, zero outside DONE
//    i_abort    in   1    present only when SERPENT_DE_ABORT_EN is defined
//  Build option
//    SERPENT_DE_ABORT_EN : adds i_abort. In BUSY or DONE it returns the
//                          block to IDLE and discards the block. In IDLE it
//                          blocks an accept.
// ============================================================================
module serpent_de_iter (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_data,
  output logic [5:0]   o_key_idx,
  input  logic [127:0] i_subkey,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_data
`ifdef SERPENT_DE_ABORT_EN
  ,
  input  logic         i_abort
`endif
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [5:0] c_KEY_LAST = 6'd32;

  // Inverse S-box tables, entry n in nibble n (entry 0 at the LSB).
  localparam logic [63:0] c_INV_S0 = 64'h289F_74E1_C56A_0B3D;
  localparam logic [63:0] c_INV_S1 = 64'h0AD1_974B_3C6F_E285;
  localparam logic [63:0] c_INV_S2 = 64'h7A85_D630_21EB_4F9C;
  localparam logic [63:0] c_INV_S3 = 64'h1F84_2C53_D6EB_7A90;
  localparam logic [63:0] c_INV_S4 = 64'h1DF4_6BC2_E79A_3805;
  localparam logic [63:0] c_INV_S5 = 64'h0AC7_356B_ED14_92F8;
  localparam logic [63:0] c_INV_S6 = 64'hB8C2_7E94_0635_D1AF;
  localparam logic [63:0] c_INV_S7 = 64'h241A_7BC5_8FE9_D603;

  logic [1:0]   r_state;
  logic [1:0]   w_state_nx;
  logic [127:0] r_x;
  logic [127:0] w_x_nx;
  logic [4:0]   r_cnt;
  logic [4:0]   w_cnt_nx;
  logic [127:0] w_round;
  logic         w_abort;

`ifdef SERPENT_DE_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] inv_table(input logic [2:0] idx);
    logic [63:0] t;
    case (idx)
      3'd0:    t = c_INV_S0;
      3'd1:    t = c_INV_S1;
      3'd2:    t = c_INV_S2;
      3'd3:    t = c_INV_S3;
      3'd4:    t = c_INV_S4;
      3'd5:    t = c_INV_S5;
      3'd6:    t = c_INV_S6;
      default: t = c_INV_S7;
    endcase
    return t;
  endfunction

  // Bitsliced S-box: column j is the nibble {w3[j], w2[j], w1[j], w0[j]}.
  function automatic logic [127:0] inv_sbox(input logic [2:0] idx,
                                            input logic [127:0] x);
    logic [63:0]  t;
    logic [3:0]   v;
    logic [3:0]   y;
    logic [127:0] r;
    t = inv_table(idx);
    r = '0;
    for (int j = 0; j < 32; j++) begin
      v = {x[96+j], x[64+j], x[32+j], x[j]};
      y = t[{v, 2'b00} +: 4];
      r[j]    = y[0];
      r[32+j] = y[1];
      r[64+j] = y[2];
      r[96+j] = y[3];
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_lt(input logic [127:0] x);
    logic [31:0] w0, w1, w2, w3;
    w0 = x[31:0];
    w1 = x[63:32];
    w2 = x[95:64];
    w3 = x[127:96];
    w2 = ror32(w2, 22);
    w0 = ror32(w0, 5);
    w2 = w2 ^ w3 ^ (w1 << 7);
    w0 = w0 ^ w1 ^ w3;
    w3 = ror32(w3, 7);
    w1 = ror32(w1, 1);
    w3 = w3 ^ w2 ^ (w0 << 3);
    w1 = w1 ^ w0 ^ w2;
    w2 = ror32(w2, 3);
    w0 = ror32(w0, 13);
    return {w3, w2, w1, w0};
  endfunction

  // The first inverse round (cnt==31) skips the inverse LT because the last
  // encryption round ends with a key mix instead of the linear transform.
  // cnt mod 8 is cnt[2:0], so cnt==31 selects InvS7.
  always_comb begin
    w_round = inv_sbox(r_cnt[2:0], (r_cnt == 5'd31) ? r_x : inv_lt(r_x)) ^ i_subkey;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= c_IDLE;
      r_x     <= '0;
      r_cnt   <= 5'd31;
    end else begin
      r_state <= w_state_nx;
      r_x     <= w_x_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nx = r_state;
    w_x_nx     = r_x;
    w_cnt_nx   = r_cnt;
    case (r_state)
      c_IDLE: begin
        if (!w_abort && i_valid) begin
          w_x_nx     = i_data ^ i_subkey;
          w_cnt_nx   = 5'd31;
          w_state_nx = c_BUSY;
        end
      end
      c_BUSY: begin
        if (w_abort) begin
          w_x_nx     = '0;
          w_cnt_nx   = 5'd31;
          w_state_nx = c_IDLE;
        end else begin
          w_x_nx   = w_round;
          // Wraps 0 -> 31 on the final round, leaving cnt ready for the next block.
          w_cnt_nx = r_cnt - 5'd1;
          if (r_cnt == 5'd0) begin
            w_state_nx = c_DONE;
          end
        end
      end
      c_DONE: begin
        if (w_abort) begin
          w_x_nx     = '0;
          w_cnt_nx   = 5'd31;
          w_state_nx = c_IDLE;
        end else if (i_ready) begin
          w_state_nx = c_IDLE;
        end
      end
      default: begin
        w_x_nx     = '0;
        w_cnt_nx   = 5'd31;
        w_state_nx = c_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    o_ready   = (r_state == c_IDLE);
    o_valid   = (r_state == c_DONE);
    o_data    = (r_state == c_DONE) ? r_x : '0;
    o_key_idx = (r_state == c_BUSY) ? {1'b0, r_cnt} : c_KEY_LAST;
  end

endmodule
`default_nettype wire
